// File: rtl/seq_mag_comparator_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mag_comparator_if
//  Description : Start/busy/done handshake and result bundle for the
//                digit-serial magnitude comparator.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_mag_comparator_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             A_gt_B;
    logic             A_eq_B;
    logic             A_lt_B;

    modport master (
        output start, signed_mode, A, B,
        input  busy, done, A_gt_B, A_eq_B, A_lt_B
    );

    modport slave (
        input  start, signed_mode, A, B,
        output busy, done, A_gt_B, A_eq_B, A_lt_B
    );
endinterface
`default_nettype wire

// File: rtl/seq_mag_comparator.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mag_comparator
//  Description : Digit-serial magnitude comparator, CHUNK bits per clock,
//                MSB chunk first with early exit; unsigned or signed mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_mag_comparator #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 2
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    seq_mag_comparator_if.slave bus
);
    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CMP  = 1'b1
    } state_t;

    state_t             r_state_q, w_state_d;
    logic [WIDTH-1:0]   r_a_q, w_a_d;
    logic [WIDTH-1:0]   r_b_q, w_b_d;
    logic [IDX_W-1:0]   r_idx_q, w_idx_d;
    logic               r_busy_q, w_busy_d;
    logic               r_done_q, w_done_d;
    logic               r_gt_q, w_gt_d;
    logic               r_eq_q, w_eq_d;
    logic               r_lt_q, w_lt_d;

    logic [WIDTH-1:0]   w_sign_mask;
    logic [WIDTH-1:0]   w_a_sh;
    logic [WIDTH-1:0]   w_b_sh;
    logic [CHUNK-1:0]   w_ca;
    logic [CHUNK-1:0]   w_cb;

    // Flipping the sign bit at latch time maps two's-complement order onto
    // unsigned order, so every chunk compare afterwards is plain unsigned.
    assign w_sign_mask = WIDTH'(bus.signed_mode) << (WIDTH - 1);

    assign w_a_sh = r_a_q >> (int'(r_idx_q) * CHUNK);
    assign w_b_sh = r_b_q >> (int'(r_idx_q) * CHUNK);
    assign w_ca   = w_a_sh[CHUNK-1:0];
    assign w_cb   = w_b_sh[CHUNK-1:0];

    always_comb begin
        w_state_d = r_state_q;
        w_a_d     = r_a_q;
        w_b_d     = r_b_q;
        w_idx_d   = r_idx_q;
        w_busy_d  = r_busy_q;
        w_done_d  = 1'b0;
        w_gt_d    = r_gt_q;
        w_eq_d    = r_eq_q;
        w_lt_d    = r_lt_q;

        case (r_state_q)
            S_IDLE: begin
                if (bus.start) begin
                    w_a_d     = bus.A ^ w_sign_mask;
                    w_b_d     = bus.B ^ w_sign_mask;
                    w_idx_d   = IDX_W'(N - 1);
                    w_gt_d    = 1'b0;
                    w_eq_d    = 1'b0;
                    w_lt_d    = 1'b0;
                    w_busy_d  = 1'b1;
                    w_state_d = S_CMP;
                end
            end
            S_CMP: begin
                if (w_ca != w_cb) begin
                    w_gt_d    = (w_ca > w_cb);
                    w_lt_d    = (w_ca < w_cb);
                    w_done_d  = 1'b1;
                    w_busy_d  = 1'b0;
                    w_state_d = S_IDLE;
                end else if (r_idx_q == '0) begin
                    w_eq_d    = 1'b1;
                    w_done_d  = 1'b1;
                    w_busy_d  = 1'b0;
                    w_state_d = S_IDLE;
                end else begin
                    w_idx_d   = r_idx_q - IDX_W'(1);
                end
            end
            default: begin
                w_state_d = S_IDLE;
                w_busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= S_IDLE;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_idx_q   <= '0;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
            r_gt_q    <= 1'b0;
            r_eq_q    <= 1'b0;
            r_lt_q    <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_a_q     <= w_a_d;
            r_b_q     <= w_b_d;
            r_idx_q   <= w_idx_d;
            r_busy_q  <= w_busy_d;
            r_done_q  <= w_done_d;
            r_gt_q    <= w_gt_d;
            r_eq_q    <= w_eq_d;
            r_lt_q    <= w_lt_d;
        end
    end

    assign bus.busy   = r_busy_q;
    assign bus.done   = r_done_q;
    assign bus.A_gt_B = r_gt_q;
    assign bus.A_eq_B = r_eq_q;
    assign bus.A_lt_B = r_lt_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_mag_comparator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_mag_comparator
//  Description : Scoreboard bench for seq_mag_comparator in three
//                configurations: 16/2, 8/4 and 8/8 (WIDTH/CHUNK).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mag_comparator;

    typedef struct {
        logic [2:0] flags;   // {gt, eq, lt}
        int         acc;
        int         done_e;
    } exp_t;

    logic clk;
    logic rst_n;

    logic [2:0]        start_v;
    logic [2:0]        sgn_v;
    logic [2:0][15:0]  a_v;
    logic [2:0][15:0]  b_v;
    logic [2:0]        busy_v;
    logic [2:0]        done_v;
    logic [2:0][2:0]   flg_v;

    seq_mag_comparator_if #(.WIDTH(16)) if0 ();
    seq_mag_comparator_if #(.WIDTH(8))  if1 ();
    seq_mag_comparator_if #(.WIDTH(8))  if2 ();

    seq_mag_comparator #(.WIDTH(16), .CHUNK(2)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    seq_mag_comparator #(.WIDTH(8),  .CHUNK(4)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    seq_mag_comparator #(.WIDTH(8),  .CHUNK(8)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    assign if0.start = start_v[0];  assign if0.signed_mode = sgn_v[0];
    assign if1.start = start_v[1];  assign if1.signed_mode = sgn_v[1];
    assign if2.start = start_v[2];  assign if2.signed_mode = sgn_v[2];
    assign if0.A = a_v[0];          assign if0.B = b_v[0];
    assign if1.A = a_v[1][7:0];     assign if1.B = b_v[1][7:0];
    assign if2.A = a_v[2][7:0];     assign if2.B = b_v[2][7:0];

    assign busy_v[0] = if0.busy;  assign done_v[0] = if0.done;
    assign busy_v[1] = if1.busy;  assign done_v[1] = if1.done;
    assign busy_v[2] = if2.busy;  assign done_v[2] = if2.done;
    assign flg_v[0]  = {if0.A_gt_B, if0.A_eq_B, if0.A_lt_B};
    assign flg_v[1]  = {if1.A_gt_B, if1.A_eq_B, if1.A_lt_B};
    assign flg_v[2]  = {if2.A_gt_B, if2.A_eq_B, if2.A_lt_B};

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         sel      = 0;
    bit         mon_en   = 1'b0;
    logic [2:0] last_flags = 3'b000;
    exp_t       q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cfg %0d, cycle %0d)", tag, act, exp, sel, cyc);
        end
    endtask

    function automatic int w_of(input int s);
        return (s == 0) ? 16 : 8;
    endfunction

    function automatic int c_of(input int s);
        case (s)
            0:       return 2;
            1:       return 4;
            default: return 8;
        endcase
    endfunction

    // Reference: full-value compare, independent of chunking.
    function automatic logic [2:0] ref_flags(input logic [15:0] a, input logic [15:0] b,
                                             input bit s, input int w);
        longint sa, sb;
        sa = longint'(a);
        sb = longint'(b);
        if (s && a[w-1]) sa = sa - (longint'(1) << w);
        if (s && b[w-1]) sb = sb - (longint'(1) << w);
        if (sa > sb) return 3'b100;
        if (sa < sb) return 3'b001;
        return 3'b010;
    endfunction

    function automatic int ref_j(input logic [15:0] a, input logic [15:0] b, input int w, input int c);
        logic [15:0] x;
        x = a ^ b;
        for (int p = w - 1; p >= 0; p--) begin
            if (x[p]) return (w - 1 - p) / c + 1;
        end
        return w / c;
    endfunction

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (q.size() > 0 && cyc >= q[0].done_e) begin
                check("done_pulse", done_v[sel], 1'b1);
                check("flags_at_done", flg_v[sel], q[0].flags);
                check("busy_at_done", busy_v[sel], 1'b0);
                last_flags = q[0].flags;
                void'(q.pop_front());
            end else begin
                logic exp_busy;
                exp_busy = (q.size() > 0) && (cyc >= q[0].acc);
                check("busy", busy_v[sel], exp_busy);
                check("done_quiet", done_v[sel], 1'b0);
                check("flags_hold", flg_v[sel], exp_busy ? 3'b000 : last_flags);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic start_cmp(input logic [15:0] a, input logic [15:0] b, input bit s, output int j);
        int          w, c;
        logic [15:0] mask;
        exp_t        e;
        w    = w_of(sel);
        c    = c_of(sel);
        mask = (w == 16) ? 16'hFFFF : 16'h00FF;
        a    = a & mask;
        b    = b & mask;
        a_v[sel]     = a;
        b_v[sel]     = b;
        sgn_v[sel]   = s;
        start_v[sel] = 1'b1;
        j        = ref_j(a, b, w, c);
        e.flags  = ref_flags(a, b, s, w);
        e.acc    = cyc + 1;
        e.done_e = cyc + 1 + j;
        q.push_back(e);
        @(posedge clk); #1;
        start_v[sel] = 1'b0;
        a_v[sel]     = 16'($urandom);
        b_v[sel]     = 16'($urandom);
        sgn_v[sel]   = ~s;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (q.size() > 0 && n < 200);
        if (q.size() > 0) begin
            check("timeout_pending", q.size(), 0);
            q.delete();
        end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic check_reset_state(input int s);
        check("rst_busy",  busy_v[s], 1'b0);
        check("rst_done",  done_v[s], 1'b0);
        check("rst_flags", flg_v[s],  3'b000);
    endtask

    task automatic run_suite(input int s);
        int          w, n, j, d;
        logic [15:0] mask, top;
        sel  = s;
        w    = w_of(s);
        n    = w / c_of(s);
        mask = (w == 16) ? 16'hFFFF : 16'h00FF;
        top  = 16'(1) << (w - 1);

        start_cmp(16'h1234, 16'h1234, 1'b0, j); wait_idle();
        start_cmp(top, mask >> 1, 1'b0, j);     wait_idle();
        start_cmp(top, mask >> 1, 1'b1, j);     wait_idle();
        start_cmp(mask, mask - 1, 1'b1, j);     wait_idle();

        // A start while busy must be ignored.
        if (n >= 2) begin
            start_cmp(16'h0001, 16'h0002, 1'b0, j);
            d = (n >= 4) ? 2 : n - 2;
            repeat (d) begin @(posedge clk); #1; end
            a_v[sel] = mask; b_v[sel] = 16'h0000; sgn_v[sel] = 1'b0; start_v[sel] = 1'b1;
            @(posedge clk); #1;
            start_v[sel] = 1'b0;
            wait_idle();
        end

        // Asynchronous reset in the middle of a compare.
        start_cmp(16'h00FF, 16'h00FF, 1'b0, j);
        d = (n > 4) ? 4 : n - 1;
        repeat (d) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        q.delete();
        last_flags = 3'b000;
        check_reset_state(s);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_cmp(16'd5, 16'd3, 1'b0, j); wait_idle();

        // Back-to-back: second start driven in the done cycle.
        start_cmp(16'h0F0F, 16'h0F0E, 1'b0, j);
        repeat (j) begin @(posedge clk); #1; end
        start_cmp(16'h0003, 16'h8003, 1'b1, j);
        wait_idle();

        for (int i = 0; i < 6; i++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
            start_cmp(ra, rb, 1'($urandom_range(0, 1)), j);
            wait_idle();
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start_v = '0;
        sgn_v   = '0;
        a_v     = '0;
        b_v     = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) check_reset_state(s);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        for (int s = 0; s < 3; s++) begin
            last_flags = flg_v[s] === 3'bxxx ? 3'b000 : last_flags;
            run_suite(s);
            // Move to the next configuration from a clean reset.
            mon_en = 1'b0;
            rst_n  = 1'b0;
            last_flags = 3'b000;
            @(posedge clk); #1;
            rst_n  = 1'b1;
            mon_en = 1'b1;
            @(posedge clk); #1;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
